// File: rtl/comp_pkg.sv
// Shared types and constants for the instruction fetch path.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE,
    ERR
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV sys_clk cycles.
// Also reused as the display scan strobe.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: free-run or single-step fetches from an
// external program memory, with ack timeout and halt-to-recover error state.
module fetch_ctrl
  import comp_pkg::*;
#(
  parameter int unsigned MEM_SIZE    = 64,
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        run,
  input  logic        step,
  input  logic        halt,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        err
);

  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

  fetch_state_t  state, state_n;
  logic [31:0]   pc;
  logic [31:0]   pc_inc;
  logic [31:0]   pc_wrap;
  logic [TW-1:0] timer;
  logic          tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .tick    (tick)
  );

  assign pc_inc  = pc + PC_STEP;
  assign pc_wrap = (pc_inc >= 32'(MEM_SIZE)) ? '0 : pc_inc;

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!halt && ((run && tick) || step)) state_n = FETCH;
      FETCH: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (mem_ack)             state_n = DONE;
        else if (timer == TLAST) state_n = ERR;
      end
      DONE:    state_n = IDLE;
      ERR:     if (halt) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with it.
  // NOTE: only control/datapath flops exist here; all get an async reset value.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= IDLE;
      pc          <= '0;
      timer       <= '0;
      instr       <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      mem_req     <= (state_n == FETCH);
      instr_valid <= (state_n == DONE);
      busy        <= (state_n != IDLE);
      err         <= (state_n == ERR);
      if (state == FETCH && mem_ack) instr <= mem_rdata;
      if (state == DONE) pc <= pc_wrap;
      if (state == FETCH && state_n == FETCH) timer <= timer + TW'(1);
      else                                    timer <= '0;
    end
  end

  // pc only moves in DONE, so the address is stable for the whole fetch.
  assign mem_addr = pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural memory responder and a
// scoreboard of expected (address, word) pairs popped on instr_valid.
module tb_fetch_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int MEM_SIZE    = 16;
  localparam int ACK_TIMEOUT = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        sys_clk   = 1'b0;
  logic        sys_rst   = 1'b0;
  logic        run       = 1'b0;
  logic        step      = 1'b0;
  logic        halt      = 1'b0;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        err;

  logic [31:0] mem [4] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'h0BADC0DE};

  exp_t        exp_q[$];
  exp_t        exp_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          ack_delay = 0;
  int          req_cycles = 0;
  logic        late_ack = 1'b0;
  logic [31:0] ack_addr = '0;
  int          n_valid  = 0;
  int          n_req_rise = 0;
  logic        req_prev = 1'b0;

  fetch_ctrl #(
    .MEM_SIZE    (MEM_SIZE),
    .TICK_DIV    (TICK_DIV),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .run         (run),
    .step        (step),
    .halt        (halt),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .err         (err)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Memory: ack after ack_delay FETCH cycles; late_ack forces a stray strobe.
  always @(negedge sys_clk) begin
    if (mem_req && req_cycles == ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr[3:2]];
      ack_addr  = mem_addr;
    end else begin
      mem_ack   = late_ack;
      mem_rdata = 32'h5555AAAA;
    end
    req_cycles = mem_req ? req_cycles + 1 : 0;
  end

  always @(negedge sys_clk) begin
    if (mem_req && !req_prev) n_req_rise++;
    req_prev = mem_req;
    if (instr_valid) begin
      n_valid++;
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("sb_addr", ack_addr, exp_e.addr);
        check("sb_instr", instr, exp_e.data);
      end
    end
  end

  task automatic clk1();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clkn(input int n);
    repeat (n) clk1();
  endtask

  // Leave the bench just before an edge that samples tick=1.
  task automatic align_tick();
    while (((cyc + 1) % TICK_DIV) != 0) clk1();
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back('{addr: a, data: mem[a[3:2]]});
  endtask

  task automatic wait_valid(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      clk1();
      if (instr_valid) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rq0, vq0, last;

    clkn(2);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    sys_rst = 1'b1;

    // Single step, ack in first FETCH cycle.
    push(32'd0);
    step = 1'b1;
    clk1();
    step = 1'b0;
    check("step_mem_req", 32'(mem_req), 32'd1);
    check("step_busy", 32'(busy), 32'd1);
    check("step_addr", mem_addr, 32'd0);
    clk1();
    check("step_latency_valid", 32'(instr_valid), 32'd1);
    check("step_instr", instr, 32'hDEADBEEF);
    clk1();
    check("step_valid_pulse", 32'(instr_valid), 32'd0);
    check("step_idle", 32'(busy), 32'd0);
    check("step_pc", mem_addr, 32'd4);
    rq0 = n_req_rise;
    clkn(6);
    check("step_no_refetch", 32'(n_req_rise - rq0), 32'd0);

    // Step on the tick edge, then a step during FETCH.
    align_tick();
    rq0 = n_req_rise;
    vq0 = n_valid;
    push(32'd4);
    run  = 1'b1;
    step = 1'b1;
    clk1();
    run = 1'b0;
    check("tick_step_req", 32'(mem_req), 32'd1);
    check("tick_step_addr", mem_addr, 32'd4);
    clk1();
    step = 1'b0;
    clkn(4);
    check("tick_step_one_fetch", 32'(n_req_rise - rq0), 32'd1);
    check("tick_step_one_valid", 32'(n_valid - vq0), 32'd1);
    check("tick_step_pc", mem_addr, 32'd8);

    // Withheld ack -> ERR after ACK_TIMEOUT cycles, halt recovers, retry.
    ack_delay = 255;
    step = 1'b1;
    clk1();
    step = 1'b0;
    check("to_addr", mem_addr, 32'd8);
    clkn(ACK_TIMEOUT - 1);
    check("to_not_early", 32'(err), 32'd0);
    check("to_req_held", 32'(mem_req), 32'd1);
    clk1();
    check("to_err", 32'(err), 32'd1);
    check("to_req_drop", 32'(mem_req), 32'd0);
    check("to_pc_kept", mem_addr, 32'd8);
    check("to_busy", 32'(busy), 32'd1);
    check("to_instr_kept", instr, mem[1]);
    clkn(3);
    check("to_err_held", 32'(err), 32'd1);
    halt = 1'b1;
    clk1();
    check("to_halt_clear", 32'(err), 32'd0);
    check("to_halt_idle", 32'(busy), 32'd0);
    halt = 1'b0;
    ack_delay = 0;
    push(32'd8);
    step = 1'b1;
    clk1();
    step = 1'b0;
    check("retry_addr", mem_addr, 32'd8);
    wait_valid("retry_valid", 4);
    clk1();
    check("retry_pc", mem_addr, 32'd12);

    // Ack in the last allowed cycle beats the timeout; pc wraps.
    ack_delay = ACK_TIMEOUT - 1;
    push(32'd12);
    step = 1'b1;
    clk1();
    step = 1'b0;
    wait_valid("last_ack_wins", 8);
    check("last_ack_no_err", 32'(err), 32'd0);
    clk1();
    check("pc_wrap", mem_addr, 32'd0);

    // Free run: 0,4,8,12,0 with one instr_valid every TICK_DIV cycles.
    ack_delay = 0;
    push(32'd0); push(32'd4); push(32'd8); push(32'd12); push(32'd0);
    align_tick();
    run  = 1'b1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid("run_valid", 8);
      if (k > 0) check("run_period", 32'(cyc - last), 32'(TICK_DIV));
      last = cyc;
    end
    run = 1'b0;
    clk1();
    check("run_pc", mem_addr, 32'd4);

    // halt blocks ticks; halt raised mid-fetch does not abort it.
    halt = 1'b1;
    run  = 1'b1;
    rq0  = n_req_rise;
    clkn(3 * TICK_DIV);
    check("halt_blocks", 32'(n_req_rise - rq0), 32'd0);
    check("halt_idle", 32'(busy), 32'd0);
    run  = 1'b0;
    halt = 1'b0;
    ack_delay = 2;
    push(32'd4);
    step = 1'b1;
    clk1();
    step = 1'b0;
    halt = 1'b1;
    wait_valid("halt_no_abort", 8);
    clk1();
    check("halt_fetch_pc", mem_addr, 32'd8);
    halt = 1'b0;

    // Reset mid-fetch at pc=8; late ack afterwards is ignored.
    ack_delay = 255;
    step = 1'b1;
    clk1();
    step = 1'b0;
    check("mid_rst_addr", mem_addr, 32'd8);
    check("mid_rst_req", 32'(mem_req), 32'd1);
    clk1();
    #2 sys_rst = 1'b0;
    #1;
    check("rst_drops_req", 32'(mem_req), 32'd0);
    check("rst_drops_busy", 32'(busy), 32'd0);
    check("rst_pc_zero", mem_addr, 32'd0);
    clk1();
    sys_rst = 1'b1;
    vq0 = n_valid;
    late_ack = 1'b1;
    clkn(2);
    late_ack = 1'b0;
    clkn(2);
    check("late_ack_ignored", 32'(n_valid - vq0), 32'd0);
    check("late_ack_no_req", 32'(mem_req), 32'd0);
    check("late_ack_instr", instr, 32'd0);
    check("late_ack_pc", mem_addr, 32'd0);

    // First tick after release comes TICK_DIV cycles later.
    sys_rst = 1'b0;
    clk1();
    sys_rst = 1'b1;
    ack_delay = 0;
    run = 1'b1;
    push(32'd0);
    clkn(TICK_DIV - 1);
    check("no_early_tick", 32'(mem_req), 32'd0);
    clk1();
    check("first_tick", 32'(mem_req), 32'd1);
    run = 1'b0;
    wait_valid("first_tick_valid", 4);
    clkn(2);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
